// File: rtl/funct_gen_burst_ctrl.sv
// Burst sequencer for the function generator: latches a burst request, holds the
// generator in config, releases it, counts samples and parks it on completion/abort.
module funct_gen_burst_ctrl #(
  parameter int AMP_W       = 8,
  parameter int CNT_W       = 16,
  parameter int CONF_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic [1:0]              wave_sel_i,
  input  logic signed [AMP_W-1:0] amp_i,
  input  logic [CNT_W-1:0]        burst_len_i,
  input  logic                    fifo_afull_i,
  input  logic                    gen_wr_en_i,
  output logic [1:0]              gen_sel_o,
  output logic signed [AMP_W-1:0] gen_amp_o,
  output logic                    gen_enh_conf_o,
  output logic                    gen_en_low_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [CNT_W-1:0]        samples_o,
  output logic                    aborted_o,
  output logic                    overrun_o
);

  localparam int CONF_W = (CONF_CYCLES > 1) ? $clog2(CONF_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, CONFIG, RUN, STOP} state_t;

  state_t                    state_q, state_d;
  logic [CONF_W-1:0]         conf_cnt_q, conf_cnt_d;
  logic [CNT_W-1:0]          len_q, len_d;
  logic [CNT_W-1:0]          samples_d;
  logic [1:0]                sel_d;
  logic signed [AMP_W-1:0]   amp_d;
  logic                      aborted_d, overrun_d;
  logic                      final_sample;

  // Terminal count is detected on the strobe that brings samples_o up to len_q.
  assign final_sample = (len_q != '0) && gen_wr_en_i && (samples_o == len_q - CNT_W'(1));

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    conf_cnt_d = conf_cnt_q;
    len_d      = len_q;
    sel_d      = gen_sel_o;
    amp_d      = gen_amp_o;
    samples_d  = samples_o;
    aborted_d  = aborted_o;
    overrun_d  = overrun_o;

    case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          sel_d      = wave_sel_i;
          amp_d      = amp_i;
          len_d      = burst_len_i;
          samples_d  = '0;
          aborted_d  = 1'b0;
          overrun_d  = 1'b0;
          conf_cnt_d = CONF_W'(CONF_CYCLES - 1);
          state_d    = CONFIG;
        end
      end
      CONFIG: begin
        if (abort_i) begin
          state_d = STOP;
        end else if (conf_cnt_q == '0) begin
          state_d = RUN;
        end else begin
          conf_cnt_d = conf_cnt_q - CONF_W'(1);
        end
      end
      RUN: begin
        if (gen_wr_en_i) samples_d = samples_o + CNT_W'(1);
        // A final sample arriving with abort still completes the burst normally.
        if (final_sample) begin
          state_d   = STOP;
          aborted_d = 1'b0;
        end else if (abort_i) begin
          state_d   = STOP;
          aborted_d = 1'b1;
        end
      end
      STOP: begin
        if (gen_wr_en_i) overrun_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Generator controls are decoded from the next state so they line up with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      conf_cnt_q     <= '0;
      len_q          <= '0;
      gen_sel_o      <= '0;
      gen_amp_o      <= '0;
      gen_enh_conf_o <= 1'b0;
      gen_en_low_o   <= 1'b1;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      samples_o      <= '0;
      aborted_o      <= 1'b0;
      overrun_o      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q        <= state_d;
      conf_cnt_q     <= conf_cnt_d;
      len_q          <= len_d;
      gen_sel_o      <= sel_d;
      gen_amp_o      <= amp_d;
      gen_enh_conf_o <= (state_d == CONFIG) || (state_d == STOP);
      gen_en_low_o   <= (state_d == RUN) ? fifo_afull_i : 1'b1;
      busy_o         <= (state_d != IDLE);
      done_o         <= (state_d == STOP);
      samples_o      <= samples_d;
      aborted_o      <= aborted_d;
      overrun_o      <= overrun_d;
    end
  end

endmodule

// File: tb/tb_funct_gen_burst_ctrl.sv
// Self-checking bench for funct_gen_burst_ctrl: directed test-plan scenarios plus random
// stimulus, both DUTs (CNT_W=16 and CNT_W=4) compared every cycle against a behavioural model.
module tb_funct_gen_burst_ctrl;

  localparam int CONF = 2;
  localparam int P_IDLE = 0, P_CONF = 1, P_RUN = 2, P_STOP = 3;

  logic        clk = 1'b0;
  logic        rst, start, abort, afull, wr;
  logic [1:0]  ws;
  logic [7:0]  amp;
  logic [15:0] len;

  logic [1:0]  sel, sel4;
  logic [7:0]  gamp, gamp4;
  logic        enh, enl, busy, done, aborted, overrun;
  logic        enh4, enl4, busy4, done4, aborted4, overrun4;
  logic [15:0] samples;
  logic [3:0]  samples4;

  int n_checks = 0;
  int n_errors = 0;

  funct_gen_burst_ctrl #(.AMP_W(8), .CNT_W(16), .CONF_CYCLES(CONF)) dut (
    .clk(clk), .rst(rst), .start_i(start), .abort_i(abort), .wave_sel_i(ws), .amp_i(amp),
    .burst_len_i(len), .fifo_afull_i(afull), .gen_wr_en_i(wr),
    .gen_sel_o(sel), .gen_amp_o(gamp), .gen_enh_conf_o(enh), .gen_en_low_o(enl),
    .busy_o(busy), .done_o(done), .samples_o(samples), .aborted_o(aborted), .overrun_o(overrun)
  );

  funct_gen_burst_ctrl #(.AMP_W(8), .CNT_W(4), .CONF_CYCLES(CONF)) dut4 (
    .clk(clk), .rst(rst), .start_i(start), .abort_i(abort), .wave_sel_i(ws), .amp_i(amp),
    .burst_len_i(len[3:0]), .fifo_afull_i(afull), .gen_wr_en_i(wr),
    .gen_sel_o(sel4), .gen_amp_o(gamp4), .gen_enh_conf_o(enh4), .gen_en_low_o(enl4),
    .busy_o(busy4), .done_o(done4), .samples_o(samples4), .aborted_o(aborted4),
    .overrun_o(overrun4)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       phase;
    int       conf_left;
    int       len;
    int       samples;
    bit       aborted, overrun, done, busy, enh, enl;
    bit [1:0] sel;
    bit [7:0] amp;
  } model_t;

  model_t m16, m4;

  function automatic model_t model_reset();
    model_t r;
    r.phase = P_IDLE; r.conf_left = 0; r.len = 0; r.samples = 0;
    r.aborted = 0; r.overrun = 0; r.done = 0; r.busy = 0; r.enh = 0; r.enl = 1;
    r.sel = 0; r.amp = 0;
    return r;
  endfunction

  // One clock edge of the burst rules; modulus is 2**CNT_W of the modelled instance.
  function automatic model_t model_step(input model_t m, input int modulus);
    model_t n = m;
    if (rst) return model_reset();
    case (m.phase)
      P_IDLE: if (start && !abort) begin
        n.sel = ws; n.amp = amp; n.len = int'(len) % modulus;
        n.samples = 0; n.aborted = 0; n.overrun = 0;
        n.conf_left = CONF; n.phase = P_CONF;
      end
      P_CONF: if (abort) n.phase = P_STOP;
              else begin
                n.conf_left = m.conf_left - 1;
                if (n.conf_left == 0) n.phase = P_RUN;
              end
      P_RUN: begin
        if (wr) n.samples = (m.samples + 1) % modulus;
        if (wr && m.len != 0 && n.samples == m.len) begin
          n.phase = P_STOP; n.aborted = 0;
        end else if (abort) begin
          n.phase = P_STOP; n.aborted = 1;
        end
      end
      default: begin
        if (wr) n.overrun = 1;
        n.phase = P_IDLE;
      end
    endcase
    n.busy = (n.phase != P_IDLE);
    n.done = (n.phase == P_STOP);
    n.enh  = (n.phase == P_CONF) || (n.phase == P_STOP);
    n.enl  = (n.phase == P_RUN) ? afull : 1'b1;
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("sel",      sel,      m16.sel);      check("sel4",      sel4,      m4.sel);
    check("amp",      gamp,     m16.amp);      check("amp4",      gamp4,     m4.amp);
    check("enh",      enh,      m16.enh);      check("enh4",      enh4,      m4.enh);
    check("en_low",   enl,      m16.enl);      check("en_low4",   enl4,      m4.enl);
    check("busy",     busy,     m16.busy);     check("busy4",     busy4,     m4.busy);
    check("done",     done,     m16.done);     check("done4",     done4,     m4.done);
    check("samples",  samples,  m16.samples);  check("samples4",  samples4,  m4.samples);
    check("aborted",  aborted,  m16.aborted);  check("aborted4",  aborted4,  m4.aborted);
    check("overrun",  overrun,  m16.overrun);  check("overrun4",  overrun4,  m4.overrun);
  endtask

  // Inputs change only at the falling edge; models advance with the rising edge.
  task automatic tick();
    @(posedge clk);
    m16 = model_step(m16, 65536);
    m4  = model_step(m4, 16);
    @(negedge clk);
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(tag, done, 1);
  endtask

  task automatic start_burst(input logic [1:0] s, input logic [7:0] a, input logic [15:0] l);
    ws = s; amp = a; len = l; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    m16 = model_reset();
    m4  = model_reset();
    rst = 1'b1; start = 0; abort = 0; afull = 0; wr = 0; ws = 0; amp = 0; len = 0;
    ticks(2);
    rst = 1'b0;
    check("rst_en_low", enl, 1);
    check("rst_busy", busy, 0);
    tick();

    // Basic burst: 2 config cycles then 5 samples.
    start_burst(2'd2, 8'h40, 16'd5);
    check("cfg1_enh", enh, 1);
    tick();
    check("cfg2_enh", enh, 1);
    check("cfg2_en_low", enl, 1);
    tick();
    check("run_en_low", enl, 0);
    check("run_enh", enh, 0);
    wr = 1'b1;
    wait_done(20, "basic_done");
    wr = 1'b0;
    check("basic_samples", samples, 5);
    check("basic_aborted", aborted, 0);
    tick();
    check("basic_idle_busy", busy, 0);
    check("basic_sel_held", sel, 2);

    // Almost-full back-pressure inside an 8-sample burst.
    start_burst(2'd0, 8'h11, 16'd8);
    ticks(2);
    for (int c = 0; c < 7; c++) begin
      afull = (c >= 3);
      wr    = (c < 4);
      tick();
      if (c == 2) check("afull_pre", enl, 0);
      if (c == 3) check("afull_hold", enl, 1);
    end
    afull = 1'b0; wr = 1'b1;
    tick();
    check("afull_release", enl, 0);
    wait_done(20, "afull_done");
    wr = 1'b0;
    check("afull_samples", samples, 8);
    tick();

    // Continuous mode ended by abort after 10 strobes.
    start_burst(2'd3, 8'h80, 16'd0);
    ticks(2);
    wr = 1'b1;
    ticks(10);
    wr = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    check("cont_done", done, 1);
    check("cont_aborted", aborted, 1);
    check("cont_samples", samples, 10);
    tick();

    // Abort coinciding with the terminal sample: the count wins.
    start_burst(2'd1, 8'hC0, 16'd5);
    ticks(2);
    wr = 1'b1;
    ticks(4);
    abort = 1'b1;
    tick();
    abort = 1'b0; wr = 1'b0;
    check("tie_done", done, 1);
    check("tie_samples", samples, 5);
    check("tie_aborted", aborted, 0);
    tick();

    // Start while busy is ignored.
    start_burst(2'd2, 8'h22, 16'd6);
    ticks(2);
    wr = 1'b1;
    ticks(2);
    ws = 2'd1; amp = 8'h99; start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_start_sel", sel, 2);
    check("busy_start_amp", gamp, 8'h22);
    wait_done(20, "busy_start_done");
    wr = 1'b0;
    check("busy_start_samples", samples, 6);
    tick();

    // Start together with abort in IDLE is ignored.
    start = 1'b1; abort = 1'b1; ws = 2'd0;
    tick();
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", busy, 0);
    tick();
    check("start_abort_busy2", busy, 0);

    // Strobe during STOP flags overrun; next start clears it.
    start_burst(2'd1, 8'h05, 16'd2);
    ticks(2);
    wr = 1'b1;
    wait_done(20, "ovr_done");
    tick();
    wr = 1'b0;
    check("ovr_flag", overrun, 1);
    check("ovr_samples", samples, 2);
    start_burst(2'd1, 8'h05, 16'd3);
    check("ovr_cleared", overrun, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();

    // 17 strobes in continuous mode: the 4-bit counter wraps to 1.
    start_burst(2'd0, 8'h01, 16'd0);
    ticks(2);
    wr = 1'b1;
    ticks(17);
    wr = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    check("wrap_samples4", samples4, 1);
    check("wrap_samples16", samples, 17);
    tick();

    // Reset in the middle of a burst.
    start_burst(2'd3, 8'h7F, 16'd10);
    ticks(2);
    wr = 1'b1;
    ticks(3);
    rst = 1'b1;
    tick();
    rst = 1'b0; wr = 1'b0;
    check("mid_rst_done", done, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_samples", samples, 0);
    check("mid_rst_sel", sel, 0);
    check("mid_rst_amp", gamp, 0);
    check("mid_rst_en_low", enl, 1);
    check("mid_rst_enh", enh, 0);
    tick();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom % 400) == 0;
      start = ($urandom % 6) == 0;
      abort = ($urandom % 40) == 0;
      wr    = $urandom % 2;
      afull = ($urandom % 4) == 0;
      ws    = 2'($urandom);
      amp   = 8'($urandom);
      len   = 16'($urandom_range(0, 20));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
